// File: rtl/pdm_stream_scheduler.sv
// Packet-granular round-robin scheduler: muxes N_SRC PDM word streams into one AXIS
// output as fixed-length packets (tag word + data), zero-padding when a source stalls.
module pdm_stream_scheduler #(
  parameter int          N_SRC                = 2,
  parameter int          WORD_BYTES           = 4,
  parameter int          PACKET_PAYLOAD_WORDS = 64,
  parameter int          TIMEOUT_CYCLES       = 1024,
  parameter logic [15:0] TAG_MAGIC            = 16'hA5A5,
  localparam int         SRC_W                = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int         DW                   = WORD_BYTES * 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC*DW-1:0] s_axis_tdata,
  input  logic [N_SRC-1:0]    s_axis_tvalid,
  output logic [N_SRC-1:0]    s_axis_tready,
  output logic [DW-1:0]       m_axis_tdata,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  output logic [SRC_W-1:0]    active_src,
  output logic                busy,
  output logic [15:0]         pad_events
);

  localparam int BEAT_W = (PACKET_PAYLOAD_WORDS > 2) ? $clog2(PACKET_PAYLOAD_WORDS) : 1;
  localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(PACKET_PAYLOAD_WORDS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_TAG, S_DATA, S_PAD} state_t;

  state_t            r_state;
  logic [SRC_W-1:0]  r_rr_ptr;
  logic [SRC_W-1:0]  r_grant;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [7:0]        r_seq [N_SRC];
  logic [15:0]       r_pad_events;

  logic [SRC_W-1:0]  w_next_grant;
  logic              w_found;
  logic              w_src_valid;
  logic [DW-1:0]     w_src_data;
  logic [DW-1:0]     w_tag;
  logic              w_beat_hs;

  // Round-robin search starts just after the last served source.
  always_comb begin
    w_next_grant = r_rr_ptr;
    w_found      = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      if (!w_found && s_axis_tvalid[SRC_W'((int'(r_rr_ptr) + k) % N_SRC)]) begin
        w_found      = 1'b1;
        w_next_grant = SRC_W'((int'(r_rr_ptr) + k) % N_SRC);
      end
    end
  end

  assign w_src_valid = s_axis_tvalid[r_grant];
  assign w_src_data  = s_axis_tdata[int'(r_grant) * DW +: DW];

  always_comb begin
    w_tag       = '0;
    w_tag[31:0] = {TAG_MAGIC, 8'(r_grant), r_seq[r_grant]};
  end

  // NOTE: every output is given a default before the case so no latch is inferred.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    s_axis_tready = '0;
    unique case (r_state)
      S_TAG: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = w_tag;
      end
      S_DATA: begin
        m_axis_tvalid          = w_src_valid;
        m_axis_tdata           = w_src_data;
        s_axis_tready[r_grant] = m_axis_tready;
      end
      S_PAD:   m_axis_tvalid = 1'b1;
      default: ;
    endcase
  end

  assign m_axis_tlast = ((r_state == S_DATA) || (r_state == S_PAD)) && (r_beat_cnt == LAST_BEAT);
  assign w_beat_hs    = m_axis_tvalid && m_axis_tready;
  assign active_src   = r_grant;
  assign busy         = (r_state != S_IDLE);
  assign pad_events   = r_pad_events;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= SRC_W'(N_SRC - 1);
      r_grant      <= '0;
      r_beat_cnt   <= '0;
      r_idle_cnt   <= '0;
      r_pad_events <= '0;
      // NOTE: seq is a tiny per-source register file, reset explicitly so tags restart at 0.
      for (int i = 0; i < N_SRC; i++) r_seq[i] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant    <= w_next_grant;
            r_beat_cnt <= '0;
            r_state    <= S_TAG;
          end
        end
        S_TAG: begin
          if (m_axis_tready) begin
            r_beat_cnt <= BEAT_W'(1);
            r_idle_cnt <= '0;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          // Only a silent source counts as idle; downstream backpressure does not.
          if (w_src_valid)                    r_idle_cnt <= '0;
          else if (r_idle_cnt == IDLE_LIMIT)  r_state    <= S_PAD;
          else                                r_idle_cnt <= r_idle_cnt + 1'b1;
          if (w_beat_hs) begin
            if (m_axis_tlast) begin
              r_state        <= S_IDLE;
              r_rr_ptr       <= r_grant;
              r_seq[r_grant] <= r_seq[r_grant] + 8'd1;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        S_PAD: begin
          if (m_axis_tready) begin
            if (m_axis_tlast) begin
              r_state        <= S_IDLE;
              r_rr_ptr       <= r_grant;
              r_seq[r_grant] <= r_seq[r_grant] + 8'd1;
              if (r_pad_events != 16'hFFFF) r_pad_events <= r_pad_events + 16'd1;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
